// File: rtl/param_loader_if.sv
// Bundle between a parameter loader, the system that starts it and the BRAM it reads.
// The slave side is the loader; the master side is the requester plus memory.
interface param_loader_if #(
    parameter int COUNT      = 10,
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 18
);
    logic                    start;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic                    mem_en;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [W-1:0]            mem_dout;
    logic [COUNT*W-1:0]      data_out;
    logic                    busy;
    logic                    done;

    modport master (
        output start, base_addr, mem_dout,
        input  mem_en, mem_addr, data_out, busy, done
    );

    modport slave (
        input  start, base_addr, mem_dout,
        output mem_en, mem_addr, data_out, busy, done
    );
endinterface

// File: rtl/param_loader.sv
// Streams COUNT consecutive words from an external BRAM, starting at a runtime base
// address, into one packed register; done is held until the next accepted start.
module param_loader #(
    parameter int COUNT      = 10,
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LAT     = 2
) (
    input  logic          clk,
    input  logic          rst,
    param_loader_if.slave bus
);
    localparam int PTR_W = $clog2(COUNT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state;
    logic [PTR_W-1:0]    rd_cnt;
    logic [PTR_W-1:0]    wr_ptr;
    logic [RD_LAT-1:0]   vld_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.mem_en   <= 1'b0;
            bus.mem_addr <= '0;
            bus.data_out <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            rd_cnt       <= '0;
            wr_ptr       <= '0;
            vld_p        <= '0;
        end else begin
            // vld_p[i] marks a read issued i+1 edges ago; the tail lines up with mem_dout
            vld_p[0] <= bus.mem_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end

            if (vld_p[RD_LAT-1]) begin
                for (int i = 0; i < COUNT; i++) begin
                    if (wr_ptr == PTR_W'(i)) begin
                        bus.data_out[i*W +: W] <= bus.mem_dout;
                    end
                end
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state        <= ISSUE;
                        bus.mem_en   <= 1'b1;
                        bus.mem_addr <= bus.base_addr;
                        bus.busy     <= 1'b1;
                        bus.done     <= 1'b0;
                        rd_cnt       <= '0;
                        wr_ptr       <= '0;
                    end
                end
                ISSUE: begin
                    rd_cnt <= rd_cnt + PTR_W'(1);
                    if (rd_cnt == PTR_W'(COUNT - 1)) begin
                        bus.mem_en <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        bus.mem_addr <= bus.mem_addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (wr_ptr == PTR_W'(COUNT)) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_loader.sv
// Bench for param_loader: five differently parameterised loaders, each with its own BRAM
// model, driven by directed and random loads and checked against a word-level model.
module tb_param_loader;
    localparam int N = 5;

    function automatic int cnt_of(input int x);
        case (x)
            3:       return 4;
            4:       return 1;
            default: return 10;
        endcase
    endfunction

    function automatic int lat_of(input int x);
        case (x)
            1:       return 1;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int aw_of(input int x);
        return (x == 3) ? 4 : 18;
    endfunction

    // Memory contents: each word is the low address byte plus a per-load offset
    function automatic logic [7:0] mem_word(input logic [17:0] a, input logic [7:0] s);
        return a[7:0] + s;
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]        start_v;
    logic [N-1:0][17:0]  base_v;
    logic [N-1:0][7:0]   seed_v;
    logic [N-1:0]        en_v, busy_v, done_v;
    logic [N-1:0][17:0]  addr_v;
    logic [N-1:0][79:0]  dout_v;
    logic [N-1:0][79:0]  last_v;
    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int C = cnt_of(g);
        localparam int L = lat_of(g);
        localparam int A = aw_of(g);

        param_loader_if #(.COUNT(C), .W(8), .ADDR_WIDTH(A)) lif ();
        logic [7:0] pipe [L];

        param_loader #(.COUNT(C), .W(8), .ADDR_WIDTH(A), .RD_LAT(L)) dut (
            .clk (clk),
            .rst (rst),
            .bus (lif.slave)
        );

        // Idle cycles return noise so a mistimed capture cannot pass by accident
        always @(posedge clk) begin
            pipe[0] <= lif.mem_en ? mem_word(18'(lif.mem_addr), seed_v[g]) : 8'($urandom);
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end

        assign lif.mem_dout  = pipe[L-1];
        assign lif.start     = start_v[g];
        assign lif.base_addr = base_v[g][A-1:0];
        assign en_v[g]       = lif.mem_en;
        assign busy_v[g]     = lif.busy;
        assign done_v[g]     = lif.done;
        assign addr_v[g]     = 18'(lif.mem_addr);
        assign dout_v[g]     = 80'(lif.data_out);
    end

    // One full load on loader x; poke>=0 pulses a stray start with a different base
    task automatic do_load(input int x, input logic [17:0] base, input logic [7:0] seed,
                           input int poke, input string tag);
        int c, l;
        logic [17:0] mask, a;
        logic [79:0] exp, mid;
        c    = cnt_of(x);
        l    = lat_of(x);
        mask = 18'((1 << aw_of(x)) - 1);
        exp  = '0;
        for (int i = 0; i < c; i++) exp[i*8 +: 8] = mem_word((base + 18'(i)) & mask, seed);
        mid = (last_v[x] & ~80'hFF) | {72'b0, exp[7:0]};

        seed_v[x]  = seed;
        base_v[x]  = base;
        start_v[x] = 1'b1;
        @(posedge clk); #1;
        for (int m = 0; m <= c + l + 2; m++) begin
            a = (base + 18'(m)) & mask;
            total++;
            if (en_v[x] !== (m < c)) begin
                bad++;
                $display("FAIL %s mem_en m=%0d got=%b want=%b", tag, m, en_v[x], (m < c));
            end
            if (m < c) begin
                total++;
                if (addr_v[x] !== a) begin
                    bad++;
                    $display("FAIL %s mem_addr m=%0d got=%0d want=%0d", tag, m, addr_v[x], a);
                end
            end
            total++;
            if (busy_v[x] !== (m < c + l + 1)) begin
                bad++;
                $display("FAIL %s busy m=%0d got=%b want=%b", tag, m, busy_v[x], (m < c + l + 1));
            end
            total++;
            if (done_v[x] !== (m >= c + l + 1)) begin
                bad++;
                $display("FAIL %s done m=%0d got=%b want=%b", tag, m, done_v[x], (m >= c + l + 1));
            end
            if (m == l + 1) begin
                total++;
                if (dout_v[x] !== mid) begin
                    bad++;
                    $display("FAIL %s first_word data_out got=%h want=%h", tag, dout_v[x], mid);
                end
            end
            start_v[x] = (m == poke);
            if (m == poke) base_v[x] = ~base;
            @(posedge clk); #1;
        end
        start_v[x] = 1'b0;
        total++;
        if (dout_v[x] !== exp) begin
            bad++;
            $display("FAIL %s data_out got=%h want=%h", tag, dout_v[x], exp);
        end
        last_v[x] = exp;
    endtask

    task automatic check_idle(input string tag);
        for (int x = 0; x < N; x++) begin
            total++;
            if ({en_v[x], busy_v[x], done_v[x]} !== 3'b000) begin
                bad++;
                $display("FAIL %s ctrl x=%0d got=%b want=000", tag, x, {en_v[x], busy_v[x], done_v[x]});
            end
            total++;
            if (addr_v[x] !== 18'd0) begin
                bad++;
                $display("FAIL %s mem_addr x=%0d got=%0d want=0", tag, x, addr_v[x]);
            end
            total++;
            if (dout_v[x] !== 80'd0) begin
                bad++;
                $display("FAIL %s data_out x=%0d got=%h want=0", tag, x, dout_v[x]);
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start_v = '1;
        for (int x = 0; x < N; x++) base_v[x] = 18'($urandom);
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst     = 1'b0;
        start_v = '0;
        @(posedge clk); #1;
        for (int x = 0; x < N; x++) begin
            total++;
            if (busy_v[x] !== 1'b0) begin
                bad++;
                $display("FAIL reset_start_ignored x=%0d busy got=%b want=0", x, busy_v[x]);
            end
        end
        last_v = '0;
    endtask

    task automatic test_basic();
        logic [17:0] b;
        b = 18'd148864;
        do_load(0, b, 8'd1 - b[7:0], -1, "basic");
        for (int i = 0; i < 10; i++) begin
            total++;
            if (dout_v[0][i*8 +: 8] !== 8'(i + 1)) begin
                bad++;
                $display("FAIL basic_word%0d got=%0d want=%0d", i, dout_v[0][i*8 +: 8], i + 1);
            end
        end
    endtask

    task automatic test_latency();
        logic [17:0] b;
        b = 18'd148864;
        do_load(1, b, 8'd1 - b[7:0], -1, "lat1");
        do_load(2, b, 8'd1 - b[7:0], -1, "lat4");
        total++;
        if (dout_v[1] !== dout_v[0] || dout_v[2] !== dout_v[0]) begin
            bad++;
            $display("FAIL latency_same_data lat1=%h lat4=%h want=%h", dout_v[1], dout_v[2], dout_v[0]);
        end
    endtask

    task automatic test_wrap();
        do_load(3, 18'd14, 8'($urandom), -1, "wrap4");
        do_load(0, 18'h3FFFB, 8'($urandom), -1, "wrap18");
    endtask

    task automatic test_back_to_back();
        do_load(0, 18'($urandom), 8'($urandom), 4, "stray_start");
        do_load(0, 18'($urandom), 8'($urandom), -1, "restart");
    endtask

    task automatic test_reset_abort();
        seed_v[0]  = 8'($urandom);
        base_v[0]  = 18'($urandom);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("abort");
        repeat (lat_of(0) + 3) begin
            @(posedge clk); #1;
            total++;
            if (dout_v[0] !== 80'd0 || en_v[0] !== 1'b0) begin
                bad++;
                $display("FAIL abort_late_capture data_out got=%h en=%b want=0", dout_v[0], en_v[0]);
            end
        end
        last_v = '0;
        do_load(0, 18'($urandom), 8'($urandom), -1, "after_abort");
    endtask

    task automatic test_count1();
        do_load(4, 18'd0, 8'hA5, -1, "count1");
        total++;
        if (dout_v[4][7:0] !== 8'hA5) begin
            bad++;
            $display("FAIL count1_word got=%h want=a5", dout_v[4][7:0]);
        end
    endtask

    task automatic test_random();
        int x, p;
        for (int n = 0; n < 12; n++) begin
            x = $urandom_range(0, N - 1);
            p = ($urandom_range(0, 1) == 1) ? $urandom_range(0, cnt_of(x) + lat_of(x) - 1) : -1;
            do_load(x, 18'($urandom), 8'($urandom), p, "random");
        end
    endtask

    initial begin
        rst     = 1'b0;
        start_v = '0;
        base_v  = '0;
        seed_v  = '0;
        last_v  = '0;
        test_reset();
        test_basic();
        test_latency();
        test_wrap();
        test_back_to_back();
        test_reset_abort();
        test_count1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
